// File: rtl/reg_status_table_if.sv
// Bus bundle between issue/commit logic and reg_status_table.
// Defining REG_STATUS_CKPT_EN adds the branch-checkpoint signals.
interface reg_status_table_if #(
    parameter int unsigned REG_W = 6,
    parameter int unsigned TAG_W = 5,
    parameter int unsigned CNT_W = 6
);
    logic             issue;
    logic [REG_W-1:0] issue_dest;
    logic [TAG_W-1:0] issue_tag;
    logic [REG_W-1:0] j_reg_no;
    logic [REG_W-1:0] k_reg_no;
    logic             j_busy;
    logic [TAG_W-1:0] j_tag;
    logic             k_busy;
    logic [TAG_W-1:0] k_tag;
    logic             commit;
    logic [REG_W-1:0] commit_reg_no;
    logic [TAG_W-1:0] commit_tag;
    logic             commit_match;
    logic             flush;
    logic [CNT_W-1:0] busy_cnt;
`ifdef REG_STATUS_CKPT_EN
    logic             ckpt_save;
    logic             ckpt_restore;
    logic             ckpt_valid;
`endif

    modport master (
`ifdef REG_STATUS_CKPT_EN
        output ckpt_save, ckpt_restore,
        input  ckpt_valid,
`endif
        output issue, issue_dest, issue_tag, j_reg_no, k_reg_no,
        output commit, commit_reg_no, commit_tag, flush,
        input  j_busy, j_tag, k_busy, k_tag, commit_match, busy_cnt
    );

    modport slave (
`ifdef REG_STATUS_CKPT_EN
        input  ckpt_save, ckpt_restore,
        output ckpt_valid,
`endif
        input  issue, issue_dest, issue_tag, j_reg_no, k_reg_no,
        input  commit, commit_reg_no, commit_tag, flush,
        output j_busy, j_tag, k_busy, k_tag, commit_match, busy_cnt
    );
endinterface

// File: rtl/reg_status_table.sv
// Register result-status table: maps each register (last index = HI/LO) to its newest ROB producer.
// Optional single-level branch checkpoint enabled by defining REG_STATUS_CKPT_EN.
module reg_status_table #(
    parameter int unsigned NUM_REGS = 33,
    parameter int unsigned REG_W    = 6,
    parameter int unsigned TAG_W    = 5,
    parameter int unsigned CNT_W    = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    reg_status_table_if.slave s_bus
);

    logic [NUM_REGS-1:0] r_busy;
    logic [NUM_REGS-1:0] w_busy_d;
    logic [TAG_W-1:0]    r_tag   [NUM_REGS];
    logic [TAG_W-1:0]    w_tag_d [NUM_REGS];
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_d;

    logic [NUM_REGS-1:0] w_issue_sel;
    logic [NUM_REGS-1:0] w_commit_addr;
    logic [NUM_REGS-1:0] w_live_match;

    logic                w_j_busy;
    logic [TAG_W-1:0]    w_j_tag;
    logic                w_k_busy;
    logic [TAG_W-1:0]    w_k_tag;

`ifdef REG_STATUS_CKPT_EN
    logic [NUM_REGS-1:0] r_sh_busy;
    logic [NUM_REGS-1:0] w_sh_busy_d;
    logic [TAG_W-1:0]    r_sh_tag   [NUM_REGS];
    logic [TAG_W-1:0]    w_sh_tag_d [NUM_REGS];
    logic [NUM_REGS-1:0] w_sh_match;
    logic                r_ckpt_valid;
    logic                w_ckpt_valid_d;
`endif

    // Address decode; entry 0 never decodes, so r0 can never be written or matched
    always_comb begin
        w_issue_sel   = '0;
        w_commit_addr = '0;
        w_live_match  = '0;
`ifdef REG_STATUS_CKPT_EN
        w_sh_match    = '0;
`endif
        for (int i = 1; i < NUM_REGS; i++) begin
            w_issue_sel[i]   = s_bus.issue && (s_bus.issue_dest == REG_W'(i));
            w_commit_addr[i] = (s_bus.commit_reg_no == REG_W'(i));
            w_live_match[i]  = r_busy[i] && (r_tag[i] == s_bus.commit_tag);
`ifdef REG_STATUS_CKPT_EN
            w_sh_match[i]    = r_sh_busy[i] && (r_sh_tag[i] == s_bus.commit_tag);
`endif
        end
    end

    // Next-state: flush > restore > save > issue/commit; issue beats commit on the same entry
    always_comb begin
        w_busy_d = r_busy;
        w_tag_d  = r_tag;
`ifdef REG_STATUS_CKPT_EN
        w_sh_busy_d    = r_sh_busy;
        w_sh_tag_d     = r_sh_tag;
        w_ckpt_valid_d = r_ckpt_valid;
`endif
        if (s_bus.flush) begin
            w_busy_d = '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                w_tag_d[i] = '0;
            end
`ifdef REG_STATUS_CKPT_EN
            w_ckpt_valid_d = 1'b0;
`endif
        end
`ifdef REG_STATUS_CKPT_EN
        else if (s_bus.ckpt_restore && r_ckpt_valid) begin
            w_busy_d = r_sh_busy;
            w_tag_d  = r_sh_tag;
            for (int i = 1; i < NUM_REGS; i++) begin
                if (s_bus.commit && w_commit_addr[i] && w_sh_match[i]) begin
                    w_busy_d[i] = 1'b0;
                    w_tag_d[i]  = '0;
                end
            end
            w_ckpt_valid_d = 1'b0;
        end
`endif
        else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (s_bus.commit && w_commit_addr[i] && w_live_match[i]) begin
                    w_busy_d[i] = 1'b0;
                    w_tag_d[i]  = '0;
                end
                if (w_issue_sel[i]) begin
                    w_busy_d[i] = 1'b1;
                    w_tag_d[i]  = s_bus.issue_tag;
                end
            end
`ifdef REG_STATUS_CKPT_EN
            if (s_bus.ckpt_save) begin
                // Shadow captures the post-edge live state, same-cycle issue included
                w_sh_busy_d    = w_busy_d;
                w_sh_tag_d     = w_tag_d;
                w_ckpt_valid_d = 1'b1;
            end else if (r_ckpt_valid) begin
                for (int i = 1; i < NUM_REGS; i++) begin
                    if (s_bus.commit && w_commit_addr[i] && w_sh_match[i]) begin
                        w_sh_busy_d[i] = 1'b0;
                        w_sh_tag_d[i]  = '0;
                    end
                end
            end
`endif
        end
        w_busy_d[0] = 1'b0;
        w_tag_d[0]  = '0;
    end

    always_comb begin
        w_cnt_d = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            w_cnt_d = w_cnt_d + CNT_W'(w_busy_d[i]);
        end
    end

    // Lookups read registered state only; unmatched numbers (0, out of range) stay idle
    always_comb begin
        w_j_busy = 1'b0;
        w_j_tag  = '0;
        w_k_busy = 1'b0;
        w_k_tag  = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (s_bus.j_reg_no == REG_W'(i)) begin
                w_j_busy = r_busy[i];
                w_j_tag  = r_busy[i] ? r_tag[i] : '0;
            end
            if (s_bus.k_reg_no == REG_W'(i)) begin
                w_k_busy = r_busy[i];
                w_k_tag  = r_busy[i] ? r_tag[i] : '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
            r_cnt  <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                r_tag[i] <= '0;
            end
        end else begin
            r_busy <= w_busy_d;
            r_tag  <= w_tag_d;
            r_cnt  <= w_cnt_d;
        end
    end

`ifdef REG_STATUS_CKPT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh_busy    <= '0;
            r_ckpt_valid <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                r_sh_tag[i] <= '0;
            end
        end else begin
            r_sh_busy    <= w_sh_busy_d;
            r_sh_tag     <= w_sh_tag_d;
            r_ckpt_valid <= w_ckpt_valid_d;
        end
    end

    assign s_bus.ckpt_valid = r_ckpt_valid;
`endif

    assign s_bus.j_busy       = w_j_busy;
    assign s_bus.j_tag        = w_j_tag;
    assign s_bus.k_busy       = w_k_busy;
    assign s_bus.k_tag        = w_k_tag;
    assign s_bus.commit_match = |(w_commit_addr & w_live_match);
    assign s_bus.busy_cnt     = r_cnt;

endmodule

// File: tb/tb_reg_status_table.sv
// Scoreboard bench for reg_status_table: stimulus queues expected lookups, a negedge monitor checks.
// Checkpoint vectors run only when REG_STATUS_CKPT_EN is defined.
module tb_reg_status_table;

    localparam int NUM_REGS = 33;
    localparam int REG_W    = 6;
    localparam int TAG_W    = 5;
    localparam int CNT_W    = 6;

    logic clk;
    logic rst_n;

    reg_status_table_if #(.REG_W(REG_W), .TAG_W(TAG_W), .CNT_W(CNT_W)) bus ();

    reg_status_table #(
        .NUM_REGS (NUM_REGS),
        .REG_W    (REG_W),
        .TAG_W    (TAG_W),
        .CNT_W    (CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .s_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int   id;
        logic jb;
        int   jt;
        logic kb;
        int   kt;
        logic cm;
        int   cnt;
        logic cv;
    } exp_t;

    exp_t q[$];
    exp_t e;
    logic obs_valid;
    logic exp_cv;
    int   checks;
    int   failures;

    task automatic cmp(input int id, input string field, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL obs%0d %s got=%0d expected=%0d", id, field, got, want);
        end
    endtask

    // Monitor: one queued expectation per observed cycle
    always @(negedge clk) begin
        if (obs_valid) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL scoreboard_underflow got=0 expected=1");
            end else begin
                e = q.pop_front();
                cmp(e.id, "j_busy",       int'(bus.j_busy),       int'(e.jb));
                cmp(e.id, "j_tag",        int'(bus.j_tag),        e.jt);
                cmp(e.id, "k_busy",       int'(bus.k_busy),       int'(e.kb));
                cmp(e.id, "k_tag",        int'(bus.k_tag),        e.kt);
                cmp(e.id, "commit_match", int'(bus.commit_match), int'(e.cm));
                cmp(e.id, "busy_cnt",     int'(bus.busy_cnt),     e.cnt);
`ifdef REG_STATUS_CKPT_EN
                cmp(e.id, "ckpt_valid",   int'(bus.ckpt_valid),   int'(e.cv));
`endif
            end
        end
    end

    task automatic idle();
        bus.issue         = 1'b0;
        bus.issue_dest    = '0;
        bus.issue_tag     = '0;
        bus.j_reg_no      = '0;
        bus.k_reg_no      = '0;
        bus.commit        = 1'b0;
        bus.commit_reg_no = '0;
        bus.commit_tag    = '0;
        bus.flush         = 1'b0;
`ifdef REG_STATUS_CKPT_EN
        bus.ckpt_save     = 1'b0;
        bus.ckpt_restore  = 1'b0;
`endif
    endtask

    // Drive one cycle; expectation describes outputs before the edge
    task automatic cyc(input int id, input logic iss, input int idst, input int itag,
                       input logic cmt, input int creg, input int ctag, input logic fl,
                       input int jr, input int kr,
                       input logic ejb, input int ejt, input logic ekb, input int ekt,
                       input logic ecm, input int ecnt);
        bus.issue         = iss;
        bus.issue_dest    = REG_W'(idst);
        bus.issue_tag     = TAG_W'(itag);
        bus.commit        = cmt;
        bus.commit_reg_no = REG_W'(creg);
        bus.commit_tag    = TAG_W'(ctag);
        bus.flush         = fl;
        bus.j_reg_no      = REG_W'(jr);
        bus.k_reg_no      = REG_W'(kr);
        q.push_back('{id, ejb, ejt, ekb, ekt, ecm, ecnt, exp_cv});
        obs_valid = 1'b1;
        @(posedge clk);
        #1;
        obs_valid = 1'b0;
        idle();
    endtask

    task automatic act_issue(input int idst, input int itag);
        bus.issue      = 1'b1;
        bus.issue_dest = REG_W'(idst);
        bus.issue_tag  = TAG_W'(itag);
        @(posedge clk);
        #1;
        idle();
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        obs_valid = 1'b0;
        exp_cv    = 1'b0;
        rst_n     = 1'b0;
        idle();
        #22;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        //   id iss dst tag  cmt reg tag fl  jr  kr   jb jt kb kt cm cnt
        // WAW rename and tag-matched commit; tag 0 is a legal producer
        cyc( 1, 1,  5,  0,   0,  0,  0,  0,  5,  0,   0, 0, 0, 0, 0, 0);
        cyc( 2, 1,  7,  3,   0,  0,  0,  0,  5,  5,   1, 0, 1, 0, 0, 1);
        cyc( 3, 1,  7,  9,   0,  0,  0,  0,  7,  5,   1, 3, 1, 0, 0, 2);
        cyc( 4, 0,  0,  0,   1,  7,  3,  0,  7,  0,   1, 9, 0, 0, 0, 2);
        cyc( 5, 0,  0,  0,   1,  7,  9,  0,  7,  0,   1, 9, 0, 0, 1, 2);
        cyc( 6, 0,  0,  0,   1,  5,  0,  0,  7,  5,   0, 0, 1, 0, 1, 1);
        // Issue and commit together: same register (issue wins), then different registers
        cyc( 7, 1,  4,  2,   0,  0,  0,  0,  5,  4,   0, 0, 0, 0, 0, 0);
        cyc( 8, 1,  4, 12,   1,  4,  2,  0,  4,  0,   1, 2, 0, 0, 1, 1);
        cyc( 9, 1,  9, 20,   1,  4, 12,  0,  4,  0,   1,12, 0, 0, 1, 1);
        // r0 never written; HI/LO at index 32; index 33 out of range
        cyc(10, 1,  0,  6,   0,  0,  0,  0,  9,  4,   1,20, 0, 0, 0, 1);
        cyc(11, 1, 32,  1,   0,  0,  0,  0,  0, 33,   0, 0, 0, 0, 0, 1);
        cyc(12, 0,  0,  0,   1,  0,  0,  0, 32, 32,   1, 1, 1, 1, 0, 2);

        for (int i = 1; i < NUM_REGS; i++) begin
            act_issue(i, i % 32);
        end
        // Flush overrides same-cycle issue and commit
        cyc(13, 1,  3,  7,   1, 31, 31,  1, 31, 32,   1,31, 1, 0, 1,32);
        cyc(14, 1, 10,  4,   0,  0,  0,  0,  3, 31,   0, 0, 0, 0, 0, 0);
        cyc(15, 0,  0,  0,   1, 10,  5,  0, 10,  0,   1, 4, 0, 0, 0, 1);
        // Asynchronous reset: cleared at the next negedge with no rising edge in between
        rst_n = 1'b0;
        cyc(16, 0,  0,  0,   0,  0,  0,  0, 10,  0,   0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        cyc(17, 1,  2,  3,   0,  0,  0,  0,  2,  0,   0, 0, 0, 0, 0, 0);
        cyc(18, 0,  0,  0,   0,  0,  0,  0,  2,  0,   1, 3, 0, 0, 0, 1);

`ifdef REG_STATUS_CKPT_EN
        cyc(19, 1,  2,  1,   0,  0,  0,  0,  2,  0,   1, 3, 0, 0, 0, 1);
        bus.ckpt_save = 1'b1;
        cyc(20, 0,  0,  0,   0,  0,  0,  0,  2,  0,   1, 1, 0, 0, 0, 1);
        exp_cv = 1'b1;
        cyc(21, 1,  2,  5,   0,  0,  0,  0,  2,  0,   1, 1, 0, 0, 0, 1);
        cyc(22, 1,  6,  6,   0,  0,  0,  0,  2,  0,   1, 5, 0, 0, 0, 1);
        cyc(23, 0,  0,  0,   1,  2,  1,  0,  6,  0,   1, 6, 0, 0, 0, 2);
        bus.ckpt_restore = 1'b1;
        cyc(24, 0,  0,  0,   0,  0,  0,  0,  2,  6,   1, 5, 1, 6, 0, 2);
        exp_cv = 1'b0;
        // Restore without a valid checkpoint is ignored
        bus.ckpt_restore = 1'b1;
        cyc(25, 1,  8,  2,   0,  0,  0,  0,  2,  6,   0, 0, 0, 0, 0, 0);
        cyc(26, 0,  0,  0,   0,  0,  0,  0,  8,  0,   1, 2, 0, 0, 0, 1);
`endif

        @(posedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d expected=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
